// File: rtl/unified_cache.sv
// Direct-mapped, write-through, no-write-allocate cache: 4 lines x 4 words.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module unified_cache #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cache_hit,
  output logic                   ready,
  input  logic                   both_access,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  localparam int unsigned TagW = WORD_SIZE - 4;

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic                   toggle_q;
  logic [WORD_SIZE-1:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]             valid_q;
  logic [TagW-1:0]        tag_q  [4];
  logic [WORD_SIZE-1:0]   data_q [4][4];

  logic [1:0]             cpu_off, cpu_idx, lat_off, lat_idx;
  logic [TagW-1:0]        cpu_tag, lat_tag;
  logic                   match, step, expire, start;

  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[3:2];
  assign cpu_tag = cpu_addr[WORD_SIZE-1:4];
  assign lat_off = addr_q[1:0];
  assign lat_idx = addr_q[3:2];
  assign lat_tag = addr_q[WORD_SIZE-1:4];

  assign match  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // Under a shared bus the countdown only advances on alternate cycles.
  assign step   = !both_access || toggle_q;
  assign expire = (state_q == StFill || state_q == StWrite) && (cnt_q == 4'd1) && step;
  assign start  = (state_q == StIdle) && (state_d != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_read && !match) begin
          state_d = StFill;
        end else if (cpu_write) begin
          state_d = StWrite;
        end
      end
      StFill, StWrite: begin
        if (expire) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ready     = 1'b0;
    unique case (state_q)
      StFill: begin
        mem_read = 1'b1;
        mem_addr = {lat_tag, lat_idx, 2'b00};
      end
      StWrite: begin
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      StDone:  ready = 1'b1;
      default: ;
    endcase

    if (state_q == StDone)          cache_hit = 1'b1;
    else if (!cpu_read && !cpu_write) cache_hit = 1'b1;
    else if (cpu_read)              cache_hit = match;
    else                            cache_hit = 1'b0;

    cpu_rdata = match ? data_q[cpu_idx][cpu_off] : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      toggle_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= '0;
      for (int l = 0; l < 4; l++) begin
        tag_q[l] <= '0;
        for (int w = 0; w < 4; w++) data_q[l][w] <= '0;
      end
    end else begin
      rdata_q  <= cpu_rdata;
      toggle_q <= start ? 1'b0 : !toggle_q;
      if (start) begin
        cnt_q   <= 4'(LATENCY);
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end else if ((state_q == StFill || state_q == StWrite) && step) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (expire && state_q == StFill) begin
        for (int w = 0; w < 4; w++) data_q[lat_idx][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
        valid_q[lat_idx] <= 1'b1;
        tag_q[lat_idx]   <= lat_tag;
      end
      // Write-through only refreshes a resident line; misses never allocate.
      if (expire && state_q == StWrite && valid_q[lat_idx] && tag_q[lat_idx] == lat_tag) begin
        data_q[lat_idx][lat_off] <= wdata_q;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == StIdle && cpu_read && match && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (start && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/unified_cache.md
# unified_cache

Direct-mapped, write-through, no-write-allocate cache instantiated twice in the pipelined CPU: once as the instruction cache, once as the data cache. It sits between a CPU memory port and the shared backing memory. It produces the `cache_hit` / `ready` pair that the pipeline hazard/stall controller consumes as `i_cache_hit`/`i_ready` or `d_cache_hit`/`d_ready`. It consumes that controller's `both_access` to model a shared memory bus.

## Interface
- `WORD_SIZE`, 16: word width in bits. Addresses are also WORD_SIZE bits.
- `LATENCY`, 4: memory cycles per block fill or word write. Legal range 2..15.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_read` in 1: read request. Held by the CPU until `ready`.
- `cpu_write` in 1: write request. Never asserted together with `cpu_read`.
- `cpu_addr` in WORD_SIZE: word address.
- `cpu_wdata` in WORD_SIZE: write data.
- `cpu_rdata` out WORD_SIZE: read data, valid when `cache_hit`=1 with `cpu_read`=1.
- `cache_hit` out 1: combinational. 1 means the request completes this cycle or there is no request.
- `ready` out 1: one-cycle pulse when a miss or write completes.
- `both_access` in 1: the other cache is also using memory. This cache's fill/write progress runs at half rate.
- `mem_read` out 1: block read in progress.
- `mem_write` out 1: word write in progress.
- `mem_addr` out WORD_SIZE: block address for reads (low 2 bits = 0), word address for writes.
- `mem_wdata` out WORD_SIZE: write-through data.
- `mem_rdata` in 4*WORD_SIZE: block from memory, word 0 in the LSBs.

## Operation
- Geometry: 4 lines × 4 words.
  - offset = addr[1:0]
  - index = addr[3:2]
  - tag = addr[WORD_SIZE-1:4]
  - Per line: valid bit, tag, 4 data words.
- Lookup: `match` = valid[index] & (tag[index] == tag).
- `cache_hit` rule, evaluated in order:
  - 1 if state = DONE.
  - 1 if no request (`cpu_read` = `cpu_write` = 0).
  - `match` if `cpu_read` = 1.
  - 0 if `cpu_write` = 1. Every write stalls for write-through.
- `cpu_rdata`: selected word of line[index]. Holds the last value when there is no match.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - On read miss: latch address, → FILL.
  - On write: latch address and data, → WRITE.
  - Otherwise stay in IDLE.
- FILL:
  - `mem_read`=1, `mem_addr` = {latched tag, latched index, 2'b00}.
  - Countdown loaded with LATENCY on entry.
  - When the countdown expires: write `mem_rdata` into line[index], set valid, set tag, → DONE.
- WRITE:
  - `mem_write`=1, `mem_addr` = latched address, `mem_wdata` = latched data.
  - When the countdown expires → DONE.
  - On expiry, if the latched address matches a valid line, update that word. A miss does not allocate.
- DONE: `ready`=1 for one cycle, then → IDLE unconditionally.
- Half-rate progress: while `both_access`=1, the countdown decrements only on cycles where an internal toggle bit is 1. The toggle flips every cycle and clears on FILL/WRITE entry.
- Request withdrawn mid-FILL/WRITE (pipeline flush): the operation completes anyway, the line is installed, and `ready` still pulses.
- `cpu_addr` changes mid-operation: ignored. The latched address is used throughout.

## Timing
- Read hit: zero latency. `cache_hit`=1 and `cpu_rdata` are valid in the same cycle.
- Read miss detected in cycle T:
  - FILL occupies T+1..T+LATENCY (no `both_access`).
  - DONE in T+LATENCY+1, with `ready`=1, `cache_hit`=1 and `cpu_rdata` = filled word.
- Write: same schedule as a read miss, using WRITE instead of FILL.
- With `both_access` held at 1 throughout: FILL/WRITE lasts 2×LATENCY cycles.
- Reset values:
  - state IDLE, all valid bits 0, countdown 0, toggle 0.
  - `ready`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0.
  - `cache_hit` follows its combinational rule.
- Reset mid-FILL/WRITE: abort immediately. The line is not installed and the memory write is not retired.

## Configuration
- `CACHE_STATS_EN`:
  - Defined: adds outputs `hit_count` and `miss_count`, 16 bits each, saturating at 0xFFFF, cleared by `reset`.
    - `hit_count` increments on an IDLE cycle with a read hit.
    - `miss_count` increments on each IDLE→FILL or IDLE→WRITE transition.
  - Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Cold read, LATENCY=4:
  - `cpu_read` 0x0012 → `cache_hit`=0.
  - `mem_read`=1 for 4 cycles with `mem_addr`=0x0010.
  - `ready` in the 6th cycle with `cpu_rdata` = word 2 of `mem_rdata`.
  - A following read of 0x0013 hits with zero latency.
- Conflict eviction:
  - After the cold fill, read 0x0052 (index 0) → miss and fill.
  - Re-read 0x0012 → miss again, `mem_addr`=0x0010.
- Write hit:
  - Write 0x0013 = 0xBEEF with the line resident → `mem_write`=1 for 4 cycles, `mem_addr`=0x0013, `mem_wdata`=0xBEEF, then `ready`.
  - A following read of 0x0013 hits with 0xBEEF.
- Write miss:
  - Write 0x0100 = 0x1234 on a cold cache → 4-cycle memory write.
  - A following read of 0x0100 misses (no allocate).
- `both_access` held high during a read miss → FILL lasts 8 cycles, `ready` in the 10th cycle.
- `reset` pulsed in the 2nd FILL cycle:
  - `mem_read` drops immediately and state returns to IDLE.
  - Re-issuing the read misses with the full 4-cycle fill.
